// File: rtl/muldiv_unit.sv
// Iterative MIPS mult/multu/div/divu unit: 32-cycle shift-add multiply, restoring divide.
// Latency 34 cycles start-to-idle; start is ignored while busy and flush aborts without writing.
module muldiv_unit #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic        flush,
  output logic        busy,
  output logic        multWe,
  output logic [63:0] busmult
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic          sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;
  logic [31:0]   srca_q, srca_d;
  logic [31:0]   opnd_q, opnd_d;
  logic [63:0]   acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   busmult_q, busmult_d;

  logic          in_signed, in_sa, in_sb;
  logic [31:0]   abs_a, abs_b;
  logic [32:0]   mul_sum, div_shift, div_trial;
  logic [31:0]   quo_fix, rem_fix;
  logic [63:0]   result;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_CALC;
        S_CALC:  if (cnt_q == LAST) state_d = S_FIX;
        S_FIX:   state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy   = (state_q != S_IDLE);
    multWe = (state_q == S_DONE);
  end

  // op[0] = 0 selects the signed flavour for both mult and div
  always_comb begin
    in_signed = ~op[0];
    in_sa     = in_signed & srcA[31];
    in_sb     = in_signed & srcB[31];
    abs_a     = in_sa ? -srcA : srcA;
    abs_b     = in_sb ? -srcB : srcB;
  end

  always_comb begin
    mul_sum   = acc_q[0] ? ({1'b0, acc_q[63:32]} + {1'b0, opnd_q}) : {1'b0, acc_q[63:32]};
    div_shift = {acc_q[63:31]};
    div_trial = div_shift - {1'b0, opnd_q};
    quo_fix   = (sa_q ^ sb_q) ? -acc_q[31:0] : acc_q[31:0];
    rem_fix   = sa_q ? -acc_q[63:32] : acc_q[63:32];
    if (!op_q[1])  result = (sa_q ^ sb_q) ? -acc_q : acc_q;
    else if (dz_q) result = {srca_q, 32'hFFFF_FFFF};
    else           result = {rem_fix, quo_fix};
  end

  always_comb begin
    op_d      = op_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    dz_d      = dz_q;
    srca_d    = srca_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    busmult_d = busmult_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d   = op;
          sa_d   = in_sa;
          sb_d   = in_sb;
          dz_d   = op[1] & (srcB == 32'd0);
          srca_d = srcA;
          cnt_d  = '0;
          // mult: multiplicand in opnd, multiplier seeds the low half; div: dividend low, divisor in opnd
          opnd_d = op[1] ? abs_b : abs_a;
          acc_d  = {32'd0, op[1] ? abs_a : abs_b};
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (!op_q[1]) acc_d = {mul_sum, acc_q[31:1]};
        else if (!div_trial[32]) acc_d = {div_trial[31:0], acc_q[30:0], 1'b1};
        else acc_d = {div_shift[31:0], acc_q[30:0], 1'b0};
      end
      S_FIX: begin
        if (!flush) busmult_d = result;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q      <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      dz_q      <= 1'b0;
      srca_q    <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      busmult_q <= '0;
    end else begin
      op_q      <= op_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      dz_q      <= dz_d;
      srca_q    <= srca_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      busmult_q <= busmult_d;
    end
  end

  assign busmult = busmult_q;

endmodule
